// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer: op codes,
// sequencer states and the MTHI/MTLO register select.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        ITER,
        FIX
    } state_t;

    localparam logic MT_SEL_LO = 1'b0;
    localparam logic MT_SEL_HI = 1'b1;

    function automatic logic is_signed_op(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// Datapath for the iterative multiplier/divider: operand magnitudes, the
// shift-add / restoring-divide step and the final sign correction.
module muldiv_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             load,
    input  logic             step,
    input  logic             fix,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi_res,
    output logic [WIDTH-1:0] lo_res
);
    import muldiv_pkg::*;

    // acc holds the running partial product high half or the partial remainder;
    // q holds the multiplier bits being consumed or the quotient being built.
    logic [WIDTH:0]       acc;
    logic [WIDTH-1:0]     q;
    logic [WIDTH-1:0]     m;
    logic [WIDTH-1:0]     a_raw;
    logic                 div_op;
    logic                 neg_q;
    logic                 neg_r;
    logic                 zero_div;
    logic                 sa;
    logic                 sb;
    logic [WIDTH:0]       addend;
    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       shifted;
    logic [2*WIDTH-1:0]   prod;

    always_comb begin
        sa      = is_signed_op(op) & a[WIDTH-1];
        sb      = is_signed_op(op) & b[WIDTH-1];
        addend  = q[0] ? {1'b0, m} : '0;
        sum     = acc + addend;
        shifted = {acc[WIDTH-1:0], q[WIDTH-1]};
    end

    always_ff @(posedge clk) begin
        if (load) begin
            acc      <= '0;
            q        <= sa ? -a : a;
            m        <= sb ? -b : b;
            a_raw    <= a;
            div_op   <= op[1];
            neg_q    <= sa ^ sb;
            neg_r    <= sa;
            zero_div <= (b == '0);
        end else if (step) begin
            if (!div_op) begin
                acc <= {1'b0, sum[WIDTH:1]};
                q   <= {sum[0], q[WIDTH-1:1]};
            end else if (shifted >= {1'b0, m}) begin
                acc <= shifted - {1'b0, m};
                q   <= {q[WIDTH-2:0], 1'b1};
            end else begin
                acc <= shifted;
                q   <= {q[WIDTH-2:0], 1'b0};
            end
        end
    end

    // A zero divisor bypasses sign correction so HI returns the original dividend.
    always_comb begin
        prod   = {acc[WIDTH-1:0], q};
        hi_res = acc[WIDTH-1:0];
        lo_res = q;
        if (fix) begin
            if (!div_op) begin
                if (neg_q) begin
                    prod = -prod;
                end
                hi_res = prod[2*WIDTH-1:WIDTH];
                lo_res = prod[WIDTH-1:0];
            end else if (zero_div) begin
                hi_res = a_raw;
                lo_res = '1;
            end else begin
                hi_res = neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                lo_res = neg_q ? -q : q;
            end
        end
    end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner for the MIPS datapath: sequences multiply/divide ops through
// muldiv_core, handles MTHI/MTLO and stalls the pipeline while busy.
module hilo_muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mt_en,
    input  logic             mt_sel,
    input  logic [WIDTH-1:0] mt_data,
    input  logic             read_req,
    output logic [WIDTH-1:0] hi_data,
    output logic [WIDTH-1:0] lo_data,
    output logic             busy,
    output logic             done,
    output logic             stall
);
    import muldiv_pkg::*;

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    state_t           next_state;
    logic [CW-1:0]    counter;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             core_load;
    logic             core_step;
    logic             core_fix;
    logic [WIDTH-1:0] hi_res;
    logic [WIDTH-1:0] lo_res;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = PREP;
            PREP:    next_state = ITER;
            ITER:    if (counter == '0) next_state = FIX;
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Requests arriving while busy are held upstream by stall, never queued here.
    always_comb begin
        busy      = (state != IDLE);
        stall     = busy & (start | read_req | mt_en);
        core_load = (state == PREP);
        core_step = (state == ITER);
        core_fix  = (state == FIX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            counter <= '0;
        end else if (state == PREP) begin
            counter <= CW'(WIDTH - 1);
        end else if (state == ITER && counter != '0) begin
            counter <= counter - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            op_q <= op;
            a_q  <= a;
            b_q  <= b;
        end
    end

    // A same-cycle Start takes priority over a move-to write.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_data <= '0;
            lo_data <= '0;
            done    <= 1'b0;
        end else begin
            done <= (state == FIX);
            if (state == FIX) begin
                hi_data <= hi_res;
                lo_data <= lo_res;
            end else if (state == IDLE && mt_en && !start) begin
                if (mt_sel == MT_SEL_HI) begin
                    hi_data <= mt_data;
                end else begin
                    lo_data <= mt_data;
                end
            end
        end
    end

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .load   (core_load),
        .step   (core_step),
        .fix    (core_fix),
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .hi_res (hi_res),
        .lo_res (lo_res)
    );

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl: directed cases, randomized ops
// against a 64-bit arithmetic reference, stalls, move-to writes and reset.
module tb_hilo_muldiv_ctrl;

    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH + 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mt_en;
    logic        mt_sel;
    logic [31:0] mt_data;
    logic        read_req;
    logic [31:0] hi_data;
    logic [31:0] lo_data;
    logic        busy;
    logic        done;
    logic        stall;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    hilo_muldiv_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .mt_en    (mt_en),
        .mt_sel   (mt_sel),
        .mt_data  (mt_data),
        .read_req (read_req),
        .hi_data  (hi_data),
        .lo_data  (lo_data),
        .busy     (busy),
        .done     (done),
        .stall    (stall)
    );

    // Reference result {HI,LO} from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x,
                                               input logic [31:0] y);
        longint sx;
        longint sy;
        longint r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'd0: begin
                r = sx * sy;
                return 64'(r);
            end
            2'd1: return {32'b0, x} * {32'b0, y};
            2'd2: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                return {32'(sx % sy), 32'(sx / sy)};
            end
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    // Issues one op and waits (bounded) for done; reports latency, busy cycles
    // and whether HI/LO held their old values while busy.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int lat, output int busy_cnt, output bit held);
        logic [31:0] h0;
        logic [31:0] l0;
        h0 = hi_data;
        l0 = lo_data;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start    = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        held     = 1'b1;
        while (!done && lat < 60) begin
            if (busy) busy_cnt++;
            if (hi_data !== h0 || lo_data !== l0) held = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        start    = 1'b0;
        op       = 2'd0;
        a        = '0;
        b        = '0;
        mt_en    = 1'b0;
        mt_sel   = 1'b0;
        mt_data  = '0;
        read_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({hi_data, lo_data, busy, done, stall} !== 67'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_state got hi=%h lo=%h busy=%b done=%b stall=%b want all 0",
                     hi_data, lo_data, busy, done, stall);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        logic [1:0]  ops  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
        logic [31:0] as   [5] = '{32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd100, 32'h1234};
        logic [31:0] bs   [5] = '{32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'd2, 32'd7, 32'd0};
        logic [31:0] ehi  [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd2, 32'h1234};
        logic [31:0] elo  [5] = '{32'hFFFF_FFF4, 32'h0000_0001, 32'hFFFF_FFFD, 32'd14, 32'hFFFF_FFFF};
        int lat;
        int bc;
        bit held;
        for (int i = 0; i < 5; i++) begin
            run_op(ops[i], as[i], bs[i], lat, bc, held);
            vectors++;
            if (lat != LAT) begin
                miscompares++;
                $display("[TB] FAIL directed%0d_latency got %0d want %0d", i, lat, LAT);
            end
            vectors++;
            if (bc != LAT) begin
                miscompares++;
                $display("[TB] FAIL directed%0d_busy_cycles got %0d want %0d", i, bc, LAT);
            end
            vectors++;
            if (!held) begin
                miscompares++;
                $display("[TB] FAIL directed%0d_hilo_hold got changed want held", i);
            end
            vectors++;
            if ({hi_data, lo_data} !== {ehi[i], elo[i]}) begin
                miscompares++;
                $display("[TB] FAIL directed%0d_result got hi=%h lo=%h want hi=%h lo=%h",
                         i, hi_data, lo_data, ehi[i], elo[i]);
            end
            @(posedge clk);
            #1;
            vectors++;
            if (done !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL directed%0d_done_width got done=%b want 0", i, done);
            end
        end
    endtask

    task automatic test_random();
        int lat;
        int bc;
        bit held;
        logic [1:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        logic [63:0] exp;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            case ($urandom_range(0, 7))
                0:       y = 32'd0;
                1:       y = $urandom_range(1, 15);
                2:       y = -32'($urandom_range(1, 15));
                3:       y = 32'hFFFF_FFFF;
                default: y = $urandom;
            endcase
            if (i % 9 == 0) x = 32'h8000_0000;
            exp = ref_result(o, x, y);
            run_op(o, x, y, lat, bc, held);
            vectors++;
            if (lat != LAT || {hi_data, lo_data} !== exp) begin
                miscompares++;
                $display("[TB] FAIL random%0d op=%0d a=%h b=%h got hi=%h lo=%h lat=%0d want hi=%h lo=%h lat=%0d",
                         i, o, x, y, hi_data, lo_data, lat, exp[63:32], exp[31:0], LAT);
            end
        end
    endtask

    task automatic test_read_stall();
        int n;
        int stall_cnt;
        logic [31:0] x;
        logic [31:0] y;
        logic [63:0] exp;
        x   = $urandom;
        y   = $urandom;
        exp = ref_result(2'd0, x, y);
        @(negedge clk);
        start = 1'b1;
        op    = 2'd0;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start     = 1'b0;
        n         = 0;
        stall_cnt = 0;
        while (!done && n < 60) begin
            if (n >= 5) read_req = 1'b1;
            #1;
            if (stall) stall_cnt++;
            @(posedge clk);
            #1;
            n++;
        end
        #1;
        vectors++;
        if (stall_cnt != LAT - 5) begin
            miscompares++;
            $display("[TB] FAIL read_stall_cycles got %0d want %0d", stall_cnt, LAT - 5);
        end
        vectors++;
        if (stall !== 1'b0 || done !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL read_done_cycle got stall=%b done=%b want stall=0 done=1", stall, done);
        end
        vectors++;
        if ({hi_data, lo_data} !== exp) begin
            miscompares++;
            $display("[TB] FAIL read_result got %h%h want %h", hi_data, lo_data, exp);
        end
        read_req = 1'b0;
    endtask

    task automatic test_mt();
        logic [31:0] lo_before;
        lo_before = lo_data;
        @(negedge clk);
        mt_en   = 1'b1;
        mt_sel  = 1'b1;
        mt_data = 32'h0000_DEAD;
        @(posedge clk);
        #1;
        mt_en = 1'b0;
        vectors++;
        if (hi_data !== 32'h0000_DEAD || lo_data !== lo_before || done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL mthi got hi=%h lo=%h done=%b want hi=0000dead lo=%h done=0",
                     hi_data, lo_data, done, lo_before);
        end
        @(negedge clk);
        mt_en   = 1'b1;
        mt_sel  = 1'b0;
        mt_data = 32'h1357_9BDF;
        @(posedge clk);
        #1;
        mt_en = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if ({hi_data, lo_data, done} !== {32'h0000_DEAD, 32'h1357_9BDF, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL mtlo got hi=%h lo=%h done=%b want hi=0000dead lo=13579bdf done=0",
                     hi_data, lo_data, done);
        end
    endtask

    task automatic test_mt_during_busy();
        int n;
        int stall_cnt;
        @(negedge clk);
        start = 1'b1;
        op    = 2'd1;
        a     = 32'd5;
        b     = 32'd6;
        @(posedge clk);
        #1;
        start     = 1'b0;
        n         = 0;
        stall_cnt = 0;
        while (!done && n < 60) begin
            mt_en   = (n >= 3 && n < 13);
            mt_sel  = 1'b1;
            mt_data = 32'h0000_BEEF;
            #1;
            if (stall) stall_cnt++;
            @(posedge clk);
            #1;
            n++;
        end
        mt_en = 1'b0;
        vectors++;
        if (stall_cnt != 10) begin
            miscompares++;
            $display("[TB] FAIL mt_busy_stall got %0d want 10", stall_cnt);
        end
        vectors++;
        if ({hi_data, lo_data} !== {32'd0, 32'd30}) begin
            miscompares++;
            $display("[TB] FAIL mt_busy_result got hi=%h lo=%h want hi=00000000 lo=0000001e",
                     hi_data, lo_data);
        end
    endtask

    task automatic test_reset_mid_op();
        int done_seen;
        @(negedge clk);
        start = 1'b1;
        op    = 2'd2;
        a     = 32'd1000;
        b     = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        vectors++;
        if ({hi_data, lo_data, busy, done} !== 66'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_op got hi=%h lo=%h busy=%b done=%b want all 0",
                     hi_data, lo_data, busy, done);
        end
        done_seen = 0;
        for (int i = 0; i < LAT + 4; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) done_seen++;
        end
        vectors++;
        if (done_seen != 0) begin
            miscompares++;
            $display("[TB] FAIL reset_abort_quiet got %0d active cycles want 0", done_seen);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        int bc;
        bit held;
        logic [63:0] exp;
        run_op(2'd3, 32'd1000, 32'd7, lat, bc, held);
        exp = ref_result(2'd3, 32'd1000, 32'd7);
        vectors++;
        if ({hi_data, lo_data} !== exp || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL b2b_first got %h%h busy=%b want %h busy=0", hi_data, lo_data, busy, exp);
        end
        run_op(2'd0, 32'hFFFF_FF00, 32'h0000_1234, lat, bc, held);
        exp = ref_result(2'd0, 32'hFFFF_FF00, 32'h0000_1234);
        vectors++;
        if ({hi_data, lo_data} !== exp || lat != LAT) begin
            miscompares++;
            $display("[TB] FAIL b2b_second got %h%h lat=%0d want %h lat=%0d",
                     hi_data, lo_data, lat, exp, LAT);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_read_stall();
        test_mt();
        test_mt_during_busy();
        test_reset_mid_op();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv_ctrl.md
# hilo_muldiv_ctrl

Iterative multiply/divide sequencer that owns the HI/LO register pair of the MIPS datapath. It accepts MULT/MULTU/DIV/DIVU from decode, runs a WIDTH-cycle shift-add or restoring-divide loop, and handles MTHI/MTLO writes. It stalls the processor while MFHI/MFLO or a new mul/div op would see stale HI/LO. It sits beside the ALU and feeds HiData/LoData to the register-file write mux and the top-level debug ports.

## Interface
- WIDTH, 32: operand and HI/LO width. The iteration count equals WIDTH.
- Clk  in  1  clock; all state updates on the rising edge.
- Rst  in  1  synchronous, active-high reset.
- Start  in  1  mul/div instruction in decode this cycle.
- Op  in  2  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
- A  in  WIDTH  rs value (multiplicand / dividend).
- B  in  WIDTH  rt value (multiplier / divisor).
- MtEn  in  1  MTHI/MTLO write request.
- MtSel  in  1  0 selects LO, 1 selects HI.
- MtData  in  WIDTH  value for MTHI/MTLO.
- ReadReq  in  1  MFHI/MFLO in decode.
- HiData  out  WIDTH  HI register.
- LoData  out  WIDTH  LO register.
- Busy  out  1  operation in progress.
- Done  out  1  one-cycle pulse: new HI/LO valid.
- Stall  out  1  combinational stall to PC/pipeline.

## Operation
- FSM states: IDLE → PREP → ITER → FIX → IDLE.
- IDLE: when Start=1 at the edge, latch Op, A and B, go to PREP.
- PREP: for signed ops, latch |A| and |B| plus the result signs. Clear the accumulator. Counter = WIDTH-1.
- ITER: one multiply (shift-add) or restoring-divide step per cycle.
  - Counter decrements each cycle.
  - Go to FIX when the counter reaches 0 (WIDTH cycles).
- FIX: apply sign correction, then write HI/LO at the end of the cycle. Go to IDLE.
- Multiply: {HI,LO} = full 2·WIDTH-bit product, signed or unsigned per Op.
- Divide: LO = quotient, HI = remainder.
  - Signed division truncates toward zero; the remainder takes the dividend's sign.
  - -7/2 gives LO = -3, HI = -1.
- Divide by zero (B=0): HI = A, LO = all ones, for both signed and unsigned. The op still takes the full latency.
- MtEn in IDLE: writes MtData into the register selected by MtSel at the edge.
- Busy = (state != IDLE).
- Stall = Busy & (Start | ReadReq | MtEn).
- Start, MtEn or ReadReq while Busy are ignored. The pipeline holds them via Stall and re-presents them in the IDLE cycle.
- Start and MtEn in the same IDLE cycle: Start wins and the Mt write is dropped. This cannot occur with a single-issue front end.
- ReadReq in IDLE returns the current HiData/LoData with no stall.

## Timing
- Reset: state IDLE, HiData=0, LoData=0, Busy=0, Done=0, counter=0. Reset mid-operation aborts the operation with no HI/LO write.
- Start sampled at edge N:
  - PREP in cycle N+1.
  - ITER in cycles N+2 … N+WIDTH+1.
  - FIX in cycle N+WIDTH+2.
  - HI/LO updated at the end of FIX.
  - In cycle N+WIDTH+3: Done=1, Busy=0, new values visible.
  - Total latency for WIDTH=32 is 35 cycles.
- Busy is high for WIDTH+2 cycles.
- Done is high for exactly one cycle per completed op and never follows an MT write.
- Back-to-back ops: a new Start is accepted in the Done cycle (IDLE).
- HiData/LoData hold their previous values throughout Busy.

## Structure
- muldiv_pkg holds:
  - op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU)
  - the FSM state enum
  - the MT select constants
- Sub-module muldiv_core holds the accumulator/shift registers, the add/subtract step and the sign fix, with controls step/load/fix.
- hilo_muldiv_ctrl keeps the FSM, the counter, the HI/LO registers and the Stall/Done logic.

## Test plan
- MULT A=3, B=0xFFFFFFFC (-4) → after 35 cycles HI=0xFFFFFFFF, LO=0xFFFFFFF4, Done one cycle.
- MULTU A=B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV A=-7, B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU A=100, B=7 → LO=14, HI=2.
- DIVU A=0x1234, B=0 → HI=0x1234, LO=0xFFFFFFFF.
- ReadReq asserted 5 cycles after MULT Start → Stall=1 until the Done cycle, then Stall=0 and HiData holds the product.
- MTHI 0xDEAD in IDLE → HiData=0xDEAD next cycle, Done stays 0.
- MtEn during Busy → stalled, HI unchanged.
- Rst pulsed in cycle 10 of DIV → next cycle HI=LO=0, Busy=0, no Done pulse.
